mem_dump_tx: RTL and testbench
==============================

MEM_DUMP_TX -- requirements
Module: mem_dump_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter ADR_W, default 14, giving the word-address width of the dumped memory.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a dump; sampled only in IDLE.
REQ-006 SHALL have port base_adr  input  ADR_W  first word address; captured when start is accepted.
REQ-007 SHALL have port word_cnt  input  ADR_W+1  number of 32-bit words to dump; captured when start is accepted.
REQ-008 SHALL have port mem_adr_o  output  ADR_W  word address to the memory read port.
REQ-009 SHALL have port mem_rd_o  output  1  one-cycle read strobe.
REQ-010 SHALL have port mem_dat_i  input  32  read data, valid exactly one cycle after mem_rd_o (synchronous block RAM).
REQ-011 SHALL have port tx  output  1  UART serial output, idle high.
REQ-012 SHALL have port busy  output  1  high from start acceptance until the final stop bit ends.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a dump completes.

Function
REQ-014 SHALL implement FSM states IDLE, READ, LATCH, START_BIT, DATA_BITS, STOP_BIT, NEXT.
REQ-015 SHALL in IDLE with start=1 and word_cnt!=0 capture base_adr/word_cnt, set busy, and enter READ next cycle.
REQ-016 SHALL in IDLE with start=1 and word_cnt=0 pulse done the next cycle, keep busy low, and leave tx high.
REQ-017 SHALL in READ drive mem_rd_o=1 with mem_adr_o = current address for exactly one cycle, then enter LATCH.
REQ-018 SHALL in LATCH capture mem_dat_i into a 32-bit shift word, set byte index 0, and enter START_BIT.
REQ-019 SHALL send each word as 4 bytes, least-significant byte first (bits [7:0],[15:8],[23:16],[31:24]).
REQ-020 SHALL frame each byte 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit held exactly CLKS_PER_BIT cycles.
REQ-021 SHALL begin the next byte's start bit on the cycle after the previous stop bit ends (no idle gap within a word).
REQ-022 SHALL after byte 3's stop bit enter NEXT: decrement remaining count, increment address modulo 2^ADR_W (wrap from all-ones to 0).
REQ-023 SHALL in NEXT enter READ if remaining count is nonzero, else return to IDLE, clear busy, and pulse done for one cycle.
REQ-024 SHALL ignore start while busy; captured base_adr/word_cnt SHALL NOT change mid-dump.
REQ-025 SHALL accept start in the same cycle done is pulsed only after returning to IDLE (next cycle onward).
REQ-026 SHALL keep mem_rd_o low in every state except READ, and tx high in IDLE, READ, LATCH, NEXT.
REQ-027 SHALL use a baud counter of ceil(log2(CLKS_PER_BIT)) bits and a 3-bit bit counter; no other timing source.

Reset
REQ-028 SHALL on rst=1 at a clock edge force state IDLE, tx=1, busy=0, done=0, mem_rd_o=0, mem_adr_o=0, counters 0.
REQ-029 SHALL, if rst asserts mid-frame, abort the dump without a done pulse; tx SHALL be 1 from the following cycle.
REQ-030 SHALL NOT accept start in a cycle where rst=1.

Verification (CLKS_PER_BIT=4 in simulation)
REQ-031 SHALL verify single word: mem[5]=0x11223344, start with base_adr=5, word_cnt=1 -> mem_rd_o once at adr 5, tx bytes 0x44,0x33,0x22,0x11, each 40 cycles, done pulse once, busy low after.
REQ-032 SHALL verify zero count: start with word_cnt=0 -> done pulse next cycle, busy never high, tx constant 1, mem_rd_o never high.
REQ-033 SHALL verify wrap: base_adr=0x3FFF, word_cnt=2 -> reads at 0x3FFF then 0x0000, 8 bytes total, 320 tx-active cycles plus read/latch/next overhead.
REQ-034 SHALL verify start while busy: second start during byte 1 with different base_adr -> ignored, original dump completes unchanged, one done pulse.
REQ-035 SHALL verify reset mid-frame: rst asserted during a data bit of byte 2 -> tx=1, busy=0 next cycle, no done; a new start afterwards dumps correctly.
REQ-036 SHALL verify back-to-back: start asserted the cycle after done -> new dump accepted with no spurious tx transitions between dumps.

Source files
------------

// File: rtl/mem_dump_tx.sv
// Streams a block of 32-bit words from a synchronous RAM out of a UART transmitter,
// four bytes per word, least-significant byte first, 8N1 framing.
module mem_dump_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADR_W        = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [ADR_W:0]   word_cnt,
  output logic [ADR_W-1:0] mem_adr_o,
  output logic             mem_rd_o,
  input  logic [31:0]      mem_dat_i,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLatch,
    StStartBit,
    StDataBits,
    StStopBit,
    StNext
  } state_e;

  state_e             state_q, state_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [ADR_W:0]     cnt_q, cnt_d;
  logic [31:0]        word_q, word_d;
  logic [BaudW-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  logic               done_q, done_d;
  logic               bit_end;

  assign bit_end = (baud_q == BaudMax);

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        baud_d = '0;
        if (start) begin
          if (word_cnt != '0) begin
            adr_d   = base_adr;
            cnt_d   = word_cnt;
            state_d = StRead;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRead: state_d = StLatch;
      StLatch: begin
        // RAM data is valid in the cycle after the read strobe.
        word_d  = mem_dat_i;
        byte_d  = '0;
        bit_d   = '0;
        baud_d  = '0;
        state_d = StStartBit;
      end
      StStartBit: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StDataBits;
        end
      end
      StDataBits: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          // Shifting the whole word walks through all 32 bits in transmit order.
          baud_d = '0;
          word_d = {1'b0, word_q[31:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStopBit;
          end
        end
      end
      StStopBit: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d = '0;
          if (byte_q == 2'd3) begin
            cnt_d   = cnt_q - 1'b1;
            adr_d   = adr_q + 1'b1;
            state_d = StNext;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = StStartBit;
          end
        end
      end
      StNext: begin
        if (cnt_q != '0) begin
          state_d = StRead;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      adr_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      StStartBit: tx = 1'b0;
      StDataBits: tx = word_q[0];
      default:    tx = 1'b1;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign mem_rd_o  = (state_q == StRead);
  assign mem_adr_o = adr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: a cycle timeline model built from the framing rules is compared
// against the DUT every cycle, plus hand-computed checks on counts, addresses and bytes.
module tb_mem_dump_tx;

  localparam int unsigned Cpb  = 4;
  localparam int unsigned AdrW = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AdrW-1:0] base_adr;
  logic [AdrW:0]   word_cnt;
  logic [AdrW-1:0] mem_adr_o;
  logic            mem_rd_o;
  logic [31:0]     mem_dat;
  logic            tx;
  logic            busy;
  logic            done;

  mem_dump_tx #(
    .CLKS_PER_BIT(Cpb),
    .ADR_W       (AdrW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_adr (base_adr),
    .word_cnt (word_cnt),
    .mem_adr_o(mem_adr_o),
    .mem_rd_o (mem_rd_o),
    .mem_dat_i(mem_dat),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AdrW)-1];
  always @(posedge clk) if (mem_rd_o) mem_dat <= mem[mem_adr_o];

  typedef struct packed {
    logic            tx;
    logic            busy;
    logic            done;
    logic            rd;
    logic [AdrW-1:0] adr;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_now;
  exp_t idle_e;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int cyc_n = 0;
  int done_cnt, rd_cnt, busy_cyc, tx_low, done_cyc, rd_cyc;
  logic [AdrW-1:0] rd_adrs[$];
  logic tx_log[$];

  function automatic exp_t mk(input logic t, input logic b, input logic d, input logic r,
                              input logic [AdrW-1:0] a);
    exp_t e;
    e.tx = t; e.busy = b; e.done = d; e.rd = r; e.adr = a;
    return e;
  endfunction

  // Whole-dump timeline: read, latch, 4 framed bytes, next; then one done cycle.
  task automatic model_dump(input logic [AdrW-1:0] base, input logic [AdrW:0] cnt);
    for (int w = 0; w < int'(cnt); w++) begin
      logic [AdrW-1:0] a;
      logic [31:0] d;
      a = base + AdrW'(w);
      d = mem[a];
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, a));
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, '0));
      for (int b = 0; b < 4; b++) begin
        for (int k = 0; k < 10; k++) begin
          logic bv;
          if (k == 0) bv = 1'b0;
          else if (k == 9) bv = 1'b1;
          else bv = d[8*b + k - 1];
          repeat (Cpb) exp_q.push_back(mk(bv, 1'b1, 1'b0, 1'b0, '0));
        end
      end
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, '0));
    end
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, '0));
  endtask

  task automatic cyc();
    @(negedge clk);
    if (chk_en) begin
      n_vec++;
      if (tx !== exp_now.tx || busy !== exp_now.busy || done !== exp_now.done ||
          mem_rd_o !== exp_now.rd || (exp_now.rd && mem_adr_o !== exp_now.adr)) begin
        n_err++;
        $display("FAIL cycle_%0d: tx/busy/done/rd/adr got %b/%b/%b/%b/%h, want %b/%b/%b/%b/%h",
                 cyc_n, tx, busy, done, mem_rd_o, mem_adr_o,
                 exp_now.tx, exp_now.busy, exp_now.done, exp_now.rd, exp_now.adr);
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc_n; end
      if (mem_rd_o === 1'b1) begin rd_cnt++; rd_cyc = cyc_n; rd_adrs.push_back(mem_adr_o); end
      if (busy === 1'b1) begin busy_cyc++; tx_log.push_back(tx); end
      if (tx !== 1'b1) tx_low++;
    end
    cyc_n++;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_now = idle_e;
      chk_en  = 1'b1;
    end else begin
      if (!exp_now.busy && start) begin
        if (word_cnt != '0) model_dump(base_adr, word_cnt);
        else exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, '0));
      end
      exp_now = (exp_q.size() > 0) ? exp_q.pop_front() : idle_e;
    end
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  // Samples mid-bit of byte b of the word whose first busy cycle is tx_log[off].
  function automatic logic [9:0] frame(input int off, input int b);
    logic [9:0] r;
    for (int k = 0; k < 10; k++) begin
      int idx;
      idx = off + 2 + 40*b + 4*k + 1;
      r[k] = (idx < tx_log.size()) ? tx_log[idx] : 1'bx;
    end
    return r;
  endfunction

  task automatic chk_word(input string nm, input int off, input logic [31:0] w);
    for (int b = 0; b < 4; b++) chk(nm, 32'(frame(off, b)), 32'({1'b1, w[8*b +: 8], 1'b0}));
  endtask

  task automatic clear_stats();
    done_cnt = 0; rd_cnt = 0; busy_cyc = 0; tx_low = 0; done_cyc = 0; rd_cyc = 0;
    rd_adrs.delete();
    tx_log.delete();
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0;
    int i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      cyc();
      i++;
    end
    chk(nm, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic kick(input logic [AdrW-1:0] b, input logic [AdrW:0] n);
    base_adr = b;
    word_cnt = n;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  initial begin
    int d1;
    idle_e   = mk(1'b1, 1'b0, 1'b0, 1'b0, '0);
    exp_now  = idle_e;
    rst      = 1'b1;
    start    = 1'b0;
    base_adr = '0;
    word_cnt = '0;
    mem[5]       = 32'h1122_3344;
    mem[14'h3FFF] = 32'hA5C3_0F81;
    mem[0]       = 32'hDEAD_BEEF;
    mem[10]      = 32'hCAFE_F00D;
    mem[12]      = 32'h0102_0304;
    mem[13]      = 32'h0506_0708;
    mem[20]      = 32'h5A5A_0FF0;
    mem[21]      = 32'h8000_0001;
    clear_stats();

    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd", 32'(mem_rd_o), 32'd0);
    chk("rst_adr", 32'(mem_adr_o), 32'd0);
    repeat (2) cyc();

    // Single word.
    clear_stats();
    kick(14'd5, 15'd1);
    wait_done("single_done_seen", 400);
    chk("single_done_cnt", done_cnt, 1);
    chk("single_rd_cnt", rd_cnt, 1);
    chk("single_rd_adr", 32'(rd_adrs[0]), 32'h5);
    chk("single_busy_cycles", busy_cyc, 163);
    chk_word("single_byte", 0, 32'h1122_3344);
    repeat (3) cyc();
    chk("single_busy_after", 32'(busy), 32'd0);

    // Zero count.
    clear_stats();
    kick(14'd7, 15'd0);
    repeat (4) cyc();
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_busy_cycles", busy_cyc, 0);
    chk("zero_rd_cnt", rd_cnt, 0);
    chk("zero_tx_low", tx_low, 0);

    // Address wrap.
    clear_stats();
    kick(14'h3FFF, 15'd2);
    wait_done("wrap_done_seen", 800);
    chk("wrap_rd_cnt", rd_cnt, 2);
    chk("wrap_rd_adr0", 32'(rd_adrs[0]), 32'h3FFF);
    chk("wrap_rd_adr1", 32'(rd_adrs[1]), 32'h0);
    chk("wrap_busy_cycles", busy_cyc, 326);
    chk("wrap_tx_low", tx_low, 2 * 4 * 40 - 4 * 26 - 4 * 20);
    chk_word("wrap_w0", 0, 32'hA5C3_0F81);
    chk_word("wrap_w1", 163, 32'hDEAD_BEEF);
    repeat (3) cyc();

    // Start while busy, during byte 1.
    clear_stats();
    kick(14'd10, 15'd1);
    repeat (52) cyc();
    kick(14'd5, 15'd3);
    wait_done("busy_done_seen", 400);
    repeat (5) cyc();
    chk("busy_done_cnt", done_cnt, 1);
    chk("busy_rd_cnt", rd_cnt, 1);
    chk("busy_rd_adr", 32'(rd_adrs[0]), 32'd10);
    chk("busy_busy_cycles", busy_cyc, 163);
    chk_word("busy_byte", 0, 32'hCAFE_F00D);

    // Reset during a data bit of byte 2.
    clear_stats();
    kick(14'd12, 15'd2);
    repeat (92) cyc();
    chk("mid_in_data", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_tx", 32'(tx), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    repeat (20) cyc();
    chk("mid_no_done", done_cnt, 0);
    clear_stats();
    kick(14'd5, 15'd1);
    wait_done("mid_redump_seen", 400);
    chk("mid_redump_adr", 32'(rd_adrs[0]), 32'd5);
    chk_word("mid_redump_byte", 0, 32'h1122_3344);
    repeat (3) cyc();

    // Back-to-back: second start in the cycle right after done.
    clear_stats();
    kick(14'd20, 15'd1);
    wait_done("b2b_first_seen", 400);
    d1 = done_cyc;
    kick(14'd21, 15'd1);
    wait_done("b2b_second_seen", 400);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_rd_cnt", rd_cnt, 2);
    chk("b2b_gap", rd_cyc - d1, 2);
    chk_word("b2b_w0", 0, 32'h5A5A_0FF0);
    chk_word("b2b_w1", 163, 32'h8000_0001);
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
